// File: rtl/axis_packet_buffer.sv
// AXI-Stream packet buffer: DEPTH-beat circular store with a 3-state master FSM.
// Optional store-and-forward release with `define AXIS_PKT_BUF_STORE_FWD_EN (default: cut-through).
module axis_packet_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       axis_aclk,
  input  logic                       axis_areset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [$clog2(DEPTH):0]     pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = DATA_WIDTH / 8;
  localparam int BW = DATA_WIDTH + SW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_STREAM,
    ST_HOLD
  } state_t;

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] rd_beat;
  logic          wr_en, rd_en, rd_last, release_nxt;
  logic [CW-1:0] occ_nxt, pkt_nxt;
  state_t        state, state_nxt;

  assign wr_en         = s_axis_tvalid && s_axis_tready;
  assign rd_beat       = mem[rd_ptr];
  assign rd_last       = rd_beat[0];
  assign m_axis_tvalid = (state != ST_EMPTY);
  assign rd_en         = m_axis_tvalid && m_axis_tready;

  // Outputs read 0 whenever nothing is presented, so reset never exposes stale memory.
  assign {m_axis_tdata, m_axis_tstrb, m_axis_tlast} = m_axis_tvalid ? rd_beat : '0;

  always_comb begin
    occ_nxt = occupancy + CW'(wr_en) - CW'(rd_en);
    pkt_nxt = pkt_count + CW'(wr_en && s_axis_tlast) - CW'(rd_en && rd_last);
`ifdef AXIS_PKT_BUF_STORE_FWD_EN
    // Full also releases, otherwise a packet longer than DEPTH would deadlock.
    release_nxt = (pkt_nxt != '0) || (occ_nxt == FULL);
`else
    release_nxt = (occ_nxt != '0);
`endif
  end

  // Release is judged on post-edge contents, which gives the 1-cycle write-to-output latency.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt; no latch is inferred.
    state_nxt = state;
    case (state)
      ST_EMPTY:  if (release_nxt) state_nxt = ST_STREAM;
      ST_STREAM: begin
        if (!release_nxt)        state_nxt = ST_EMPTY;
        else if (!m_axis_tready) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!release_nxt)        state_nxt = ST_EMPTY;
        else if (m_axis_tready)  state_nxt = ST_STREAM;
      end
      default:                   state_nxt = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state         <= ST_EMPTY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      pkt_count     <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_nxt;
      occupancy     <= occ_nxt;
      pkt_count     <= pkt_nxt;
      s_axis_tready <= (occ_nxt != FULL);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers already discards its contents.
  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem[wr_ptr] <= {s_axis_tdata, s_axis_tstrb, s_axis_tlast};
  end

endmodule

// File: tb/tb_axis_packet_buffer.sv
// Self-checking bench for axis_packet_buffer: queue-based reference model plus directed and random traffic.
// Honours `define AXIS_PKT_BUF_STORE_FWD_EN for the release rule it expects.
module tb_axis_packet_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int SW    = DW / 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  logic          axis_aclk = 1'b0;
  logic          axis_areset;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [CW-1:0] occupancy, pkt_count;

  axis_packet_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .axis_aclk     (axis_aclk),
    .axis_areset   (axis_areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .occupancy     (occupancy),
    .pkt_count     (pkt_count)
  );

  always #5 axis_aclk = ~axis_aclk;

  int    checks = 0;
  int    errors = 0;
  beat_t q[$];
  beat_t to_send[$];
  beat_t sent[$];
  beat_t got[$];
  bit    tready_exp, tvalid_exp, last_wr, last_rd, seen_valid;
  int    first_valid_occ;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_pkts();
    int n = 0;
    foreach (q[i]) if (q[i].l) n++;
    return n;
  endfunction

  function automatic bit model_release();
`ifdef AXIS_PKT_BUF_STORE_FWD_EN
    return (model_pkts() > 0) || (q.size() == DEPTH);
`else
    return q.size() > 0;
`endif
  endfunction

  // One clock: predict handshakes from the model, advance model at the edge, compare #1 later.
  task automatic step();
    beat_t b;
    last_wr = s_axis_tvalid && tready_exp && !axis_areset;
    last_rd = tvalid_exp && m_axis_tready && !axis_areset;
    if (last_rd) begin
      b = {m_axis_tdata, m_axis_tstrb, m_axis_tlast};
      got.push_back(b);
    end
    b = {s_axis_tdata, s_axis_tstrb, s_axis_tlast};
    @(posedge axis_aclk);
    if (axis_areset) begin
      q.delete();
      tready_exp = 1'b0;
      tvalid_exp = 1'b0;
    end else begin
      if (last_rd) void'(q.pop_front());
      if (last_wr) q.push_back(b);
      tready_exp = (q.size() != DEPTH);
      tvalid_exp = model_release();
    end
    #1;
    check("occupancy", occupancy, q.size());
    check("pkt_count", pkt_count, model_pkts());
    check("s_tready", s_axis_tready, tready_exp);
    check("m_tvalid", m_axis_tvalid, tvalid_exp);
    if (tvalid_exp) begin
      check("m_tdata", m_axis_tdata, q[0].d);
      check("m_tstrb", m_axis_tstrb, q[0].s);
      check("m_tlast", m_axis_tlast, q[0].l);
    end
    if (axis_areset) begin
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tstrb", m_axis_tstrb, 0);
      check("rst_tlast", m_axis_tlast, 0);
    end
    if (!seen_valid && m_axis_tvalid) begin
      seen_valid      = 1'b1;
      first_valid_occ = int'(occupancy);
    end
  endtask

  task automatic gen_packets(input int beats, input int max_len);
    int    rem = beats;
    int    len;
    beat_t b;
    while (rem > 0) begin
      len = $urandom_range(max_len, 1);
      if (len > rem) len = rem;
      for (int i = 0; i < len; i++) begin
        b.d = $urandom;
        b.s = SW'($urandom);
        b.l = (i == len - 1);
        to_send.push_back(b);
      end
      rem -= len;
    end
  endtask

  // Streams to_send with random valid gaps and ready stalls, then compares delivered beats in order.
  task automatic run_traffic(input int budget, input int vld_pct, input int rdy_pct);
    int n = 0;
    sent = to_send;
    got.delete();
    s_axis_tvalid = 1'b0;
    while ((to_send.size() > 0 || q.size() > 0) && n < budget) begin
      if (!s_axis_tvalid && to_send.size() > 0) begin
        s_axis_tvalid = ($urandom_range(99, 0) < vld_pct);
        {s_axis_tdata, s_axis_tstrb, s_axis_tlast} = to_send[0];
      end
      m_axis_tready = ($urandom_range(99, 0) < rdy_pct);
      step();
      if (last_wr) begin
        void'(to_send.pop_front());
        s_axis_tvalid = 1'b0;
      end
      n++;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    check("traffic_done", (to_send.size() == 0 && q.size() == 0), 1);
    check("rx_count", got.size(), sent.size());
    for (int i = 0; i < got.size() && i < sent.size(); i++)
      check("rx_beat", got[i], sent[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axis_areset   = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;

    // Reset held two cycles, then released.
    step();
    step();
    axis_areset = 1'b0;
    step();
    check("rst_release_tready", s_axis_tready, 1);
    check("rst_release_occ", occupancy, 0);

    // Fill to DEPTH with single-beat packets while the sink stalls.
    for (int i = 0; i < DEPTH; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(32'h100 + i);
      s_axis_tstrb  = '1;
      s_axis_tlast  = 1'b1;
      step();
    end
    s_axis_tvalid = 1'b0;
    check("full_tready", s_axis_tready, 0);
    check("full_occ", occupancy, DEPTH);
    m_axis_tready = 1'b1;
    step();
    check("full_read_tready", s_axis_tready, 1);
    check("full_read_occ", occupancy, DEPTH - 1);
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) step();
    check("full_drained", occupancy, 0);

    // Four-beat packet 0xA0..0xA3 written back to back, sink always ready.
    for (int i = 0; i < 4; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(32'hA0 + i);
      s_axis_tstrb  = '1;
      s_axis_tlast  = (i == 3);
      step();
`ifdef AXIS_PKT_BUF_STORE_FWD_EN
      check("sf_gate_tvalid", m_axis_tvalid, (i == 3));
`else
      check("ct_tvalid", m_axis_tvalid, 1);
      check("ct_tdata", m_axis_tdata, 32'hA0 + i);
      check("ct_tlast", m_axis_tlast, (i == 3));
`endif
    end
    s_axis_tvalid = 1'b0;
`ifdef AXIS_PKT_BUF_STORE_FWD_EN
    for (int j = 0; j < 4; j++) begin
      check("sf_tdata", m_axis_tdata, 32'hA0 + j);
      check("sf_tlast", m_axis_tlast, (j == 3));
      check("sf_pkt_one", pkt_count, 1);
      step();
    end
    check("sf_pkt_zero", pkt_count, 0);
`else
    step();
`endif
    check("pkt4_empty", m_axis_tvalid, 0);
    m_axis_tready = 1'b0;

    // Reset in the middle of a partial packet discards it.
    for (int i = 0; i < 3; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'($urandom);
      s_axis_tlast  = 1'b0;
      step();
    end
    s_axis_tvalid = 1'b0;
    axis_areset   = 1'b1;
    step();
    axis_areset   = 1'b0;
    step();
    check("midrst_occ", occupancy, 0);
    check("midrst_pkt", pkt_count, 0);
    check("midrst_tvalid", m_axis_tvalid, 0);

    // Random traffic: 120 beats, packets of 1..6, random source gaps and sink stalls.
    gen_packets(120, 6);
    run_traffic(4000, 70, 60);

    // Oversize 20-beat packet with free-flowing sink.
    gen_packets(20, 20);
    while (to_send.size() > 20) void'(to_send.pop_back());
    for (int i = 0; i < to_send.size(); i++) to_send[i].l = (i == to_send.size() - 1);
    seen_valid = 1'b0;
    run_traffic(1000, 100, 100);
`ifdef AXIS_PKT_BUF_STORE_FWD_EN
    check("oversize_release_occ", first_valid_occ, DEPTH);
`else
    check("oversize_release_occ", first_valid_occ, 1);
`endif

    // Second random run with heavy stalls to exercise full/wrap repeatedly.
    gen_packets(100, 4);
    run_traffic(6000, 90, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_packet_buffer.md
AXIS_PACKET_BUFFER -- requirements
Module: axis_packet_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the tdata width in bits; it is a multiple of 8 and at least 8.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the buffer entries (beats); it is a power of 2 and at least 2.
REQ-003 SHALL have port axis_aclk, input, width 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port axis_areset, input, width 1, a synchronous active-high reset.
REQ-005 SHALL have port s_axis_tdata, input, width DATA_WIDTH, the write beat data.
REQ-006 SHALL have port s_axis_tstrb, input, width DATA_WIDTH/8, the byte strobes, stored with the beat.
REQ-007 SHALL have ports s_axis_tvalid and s_axis_tlast, input, width 1, the beat valid and end-of-packet marker.
REQ-008 SHALL have port s_axis_tready, output, width 1, asserted when the buffer can accept a beat.
REQ-009 SHALL have ports m_axis_tdata, m_axis_tstrb and m_axis_tlast, output, with the same widths as the slave side.
REQ-010 SHALL have port m_axis_tvalid, output, width 1, and port m_axis_tready, input, width 1.
REQ-011 SHALL have port occupancy, output, width $clog2(DEPTH)+1, the number of stored beats.
REQ-012 SHALL have port pkt_count, output, width $clog2(DEPTH)+1, the number of complete (tlast-terminated) packets stored.

Function
REQ-013 SHALL write beat {tdata, tstrb, tlast} on a cycle where s_axis_tvalid && s_axis_tready; the write pointer increments modulo DEPTH.
REQ-014 SHALL drive s_axis_tready = (occupancy != DEPTH), registered, so tready does not depend combinationally on m_axis_tready.
REQ-015 SHALL present the beat at the read pointer on m_axis_* whenever m_axis_tvalid=1; the beat is consumed on m_axis_tvalid && m_axis_tready and the read pointer increments modulo DEPTH.
REQ-016 SHALL hold m_axis_tdata, m_axis_tstrb, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid=1 && m_axis_tready=0.
REQ-017 SHALL have a write-to-output latency of 1 cycle: a beat written at edge N is visible on m_axis_* after edge N when the buffer was previously empty.
REQ-018 SHALL handle a simultaneous write and read by leaving occupancy unchanged; when full, a read frees the slot and tready re-asserts the next cycle (no same-cycle pass-through).
REQ-019 SHALL, when empty, never assert m_axis_tvalid in the same cycle as a write; there is no bypass path.
REQ-020 SHALL increment pkt_count on a write with tlast=1 and decrement it on a read with tlast=1; when both happen in one cycle, pkt_count is unchanged.
REQ-021 SHALL make the master side a 3-state machine: EMPTY (tvalid=0), STREAM (tvalid=1, beats flowing), HOLD (tvalid=1, tready=0).
REQ-022 SHALL transition the master state machine as follows: EMPTY->STREAM when the release condition is met; STREAM->HOLD when tready=0; HOLD->STREAM when tready=1; and STREAM or HOLD->EMPTY when the last stored beat is consumed and the release condition is false.
REQ-023 SHALL wrap both pointers and carry occupancy at width $clog2(DEPTH)+1, so full (DEPTH) and empty (0) are distinct.

Reset
REQ-024 SHALL, while axis_areset=1 on a clock edge, set the pointers, occupancy, pkt_count, m_axis_tvalid, m_axis_tdata, m_axis_tstrb, m_axis_tlast and s_axis_tready to 0, and set the state machine to EMPTY.
REQ-025 SHALL assert s_axis_tready on the first edge after axis_areset deasserts.
REQ-026 SHALL discard all stored beats, including any partial packet, on a reset during operation; the buffer contents need not be cleared.

Configuration
REQ-027 SHALL, with macro AXIS_PKT_BUF_STORE_FWD_EN defined, use the release condition pkt_count>0 || occupancy==DEPTH; a packet is forwarded only once its tlast is stored, except on full, to avoid deadlock on oversize packets.
REQ-028 SHALL, with AXIS_PKT_BUF_STORE_FWD_EN undefined, use the release condition occupancy>0 (cut-through); pkt_count is still maintained.

Verification
REQ-029 SHALL cover: reset held 2 cycles, then released -> all outputs 0 during reset; s_axis_tready=1 one edge after release; occupancy=0.
REQ-030 SHALL cover: DEPTH=16 with 16 single-beat writes and m_axis_tready=0 -> s_axis_tready=0 after the 16th write; occupancy=16; 1 read -> tready=1 on the next cycle.
REQ-031 SHALL cover: cut-through, a 4-beat packet 0xA0..0xA3 written back-to-back with m_axis_tready=1 -> m_axis_tdata 0xA0..0xA3 each 1 cycle after its write; tlast only on 0xA3.
REQ-032 SHALL cover: store-forward, the same 4-beat packet -> m_axis_tvalid stays 0 until the cycle after the 0xA3 write, then 4 consecutive beats; pkt_count goes 1->0.
REQ-033 SHALL cover: continuous write and read with random m_axis_tready stalls over 100 beats -> data order preserved, no loss or duplication, stable outputs during stalls, pointers wrap correctly.
REQ-034 SHALL cover: store-forward, a 20-beat packet into DEPTH=16 -> release at occupancy=16 and the full packet delivered intact.
